// File: rtl/corr_peak_search_pkg.sv
// Shared widths, search resolution and FSM encoding for the correlation peak search.
package corr_peak_search_pkg;

  localparam int COORD_W = 13;
  localparam int SCORE_W = 32;
  localparam int STEP_W  = 14;

  localparam int SEARCH_H_RES = 1280;
  localparam int SEARCH_V_RES = 720;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ALIGN     = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_SETTLE    = 3'd4
  } state_t;

  function automatic int axis_positions(input int lo, input int hi, input int step);
    if (step < 1 || hi < lo) return 0;
    return (hi - lo) / step + 1;
  endfunction

endpackage

// File: rtl/corr_peak_search_raster_step.sv
// Combinational raster stepper: next start coordinate and last-position flag.
module corr_raster_step
  import corr_peak_search_pkg::*;
#(
  parameter int X_MIN  = 0,
  parameter int X_MAX  = 31,
  parameter int Y_MIN  = 0,
  parameter int Y_MAX  = 31,
  parameter int X_STEP = 1,
  parameter int Y_STEP = 1
) (
  input  logic [COORD_W-1:0] x_i,
  input  logic [COORD_W-1:0] y_i,
  output logic [COORD_W-1:0] next_x_o,
  output logic [COORD_W-1:0] next_y_o,
  output logic               last_o
);

  // One extra bit so a stride past the top of the 13-bit range cannot wrap.
  logic [STEP_W-1:0] x_inc;
  logic [STEP_W-1:0] y_inc;

  always_comb begin
    x_inc    = {1'b0, x_i} + STEP_W'(X_STEP);
    y_inc    = {1'b0, y_i} + STEP_W'(Y_STEP);
    next_x_o = x_i;
    next_y_o = y_i;
    last_o   = 1'b0;
    if (x_inc <= STEP_W'(X_MAX)) begin
      next_x_o = x_inc[COORD_W-1:0];
    end else if (y_inc <= STEP_W'(Y_MAX)) begin
      next_x_o = COORD_W'(X_MIN);
      next_y_o = y_inc[COORD_W-1:0];
    end else begin
      last_o   = 1'b1;
    end
  end

endmodule

// File: rtl/corr_peak_search.sv
// Raster sweep of the scorer start coordinate, keeping the best score per sweep.
// Optional watchdog abort: define CORR_PEAK_TIMEOUT_EN.
module corr_peak_search
  import corr_peak_search_pkg::*;
#(
  parameter int X_MIN          = 0,
  parameter int X_MAX          = 31,
  parameter int Y_MIN          = 0,
  parameter int Y_MAX          = 31,
  parameter int X_STEP         = 1,
  parameter int Y_STEP         = 1,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic               iCLK,
  input  logic               iRST_N,
  input  logic               iStart,
  input  logic               iFinished,
  input  logic [SCORE_W-1:0] iScore,
  output logic [COORD_W-1:0] oXstart,
  output logic [COORD_W-1:0] oYstart,
  output logic               oBusy,
  output logic               oDone,
  output logic               oValid,
  output logic [SCORE_W-1:0] oBestScore,
  output logic [COORD_W-1:0] oBestX,
  output logic [COORD_W-1:0] oBestY,
  output logic               oTimeout,
  output state_t             oState
);

  localparam int NUM_POS = axis_positions(X_MIN, X_MAX, X_STEP) *
                           axis_positions(Y_MIN, Y_MAX, Y_STEP);

  // A single-position window would make the park point ambiguous with the sweep start.
  if (NUM_POS < 2 || X_MIN < 0 || Y_MIN < 0 || X_MAX >= SEARCH_H_RES ||
      Y_MAX >= SEARCH_V_RES || TIMEOUT_CYCLES < 1) begin : g_bad_window
    $error("corr_peak_search: window must hold at least 2 positions inside the search area");
  end

  state_t               state_q, state_d;
  logic [COORD_W-1:0]   x_q, x_d, y_q, y_d;
  logic [SCORE_W-1:0]   run_best_q, run_best_d;
  logic [COORD_W-1:0]   run_x_q, run_x_d, run_y_q, run_y_d;
  logic                 first_q, first_d;
  logic [SCORE_W-1:0]   best_q, best_d;
  logic [COORD_W-1:0]   best_x_q, best_x_d, best_y_q, best_y_d;
  logic                 valid_q, valid_d;
  logic                 done_q, done_d;
  logic                 take;
  logic [COORD_W-1:0]   next_x, next_y;
  logic                 last_pos;

  corr_raster_step #(
    .X_MIN (X_MIN),
    .X_MAX (X_MAX),
    .Y_MIN (Y_MIN),
    .Y_MAX (Y_MAX),
    .X_STEP(X_STEP),
    .Y_STEP(Y_STEP)
  ) u_step (
    .x_i     (x_q),
    .y_i     (y_q),
    .next_x_o(next_x),
    .next_y_o(next_y),
    .last_o  (last_pos)
  );

`ifdef CORR_PEAK_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tmo_q, tmo_d;
  logic             waiting;
`endif

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    run_best_d = run_best_q;
    run_x_d    = run_x_q;
    run_y_d    = run_y_q;
    first_d    = first_q;
    best_d     = best_q;
    best_x_d   = best_x_q;
    best_y_d   = best_y_q;
    valid_d    = valid_q;
    done_d     = 1'b0;
    take       = first_q || (iScore > run_best_q);
`ifdef CORR_PEAK_TIMEOUT_EN
    tmo_d      = tmo_q;
    cnt_d      = '0;
    waiting    = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (iStart) begin
          state_d    = ST_ALIGN;
          run_best_d = '0;
          first_d    = 1'b1;
`ifdef CORR_PEAK_TIMEOUT_EN
          tmo_d      = 1'b0;
`endif
        end
      end
      ST_ALIGN: begin
        if (iFinished) begin
          x_d     = COORD_W'(X_MIN);
          y_d     = COORD_W'(Y_MIN);
          state_d = ST_WAIT_BUSY;
        end
      end
      ST_WAIT_BUSY: if (!iFinished) state_d = ST_WAIT_DONE;
      ST_WAIT_DONE: if (iFinished)  state_d = ST_SETTLE;
      ST_SETTLE: begin
        // Strict compare: ties keep the earlier raster position.
        first_d = 1'b0;
        if (take) begin
          run_best_d = iScore;
          run_x_d    = x_q;
          run_y_d    = y_q;
        end
        if (!last_pos) begin
          x_d     = next_x;
          y_d     = next_y;
          state_d = ST_WAIT_BUSY;
        end else begin
          best_d   = run_best_d;
          best_x_d = run_x_d;
          best_y_d = run_y_d;
          valid_d  = 1'b1;
          done_d   = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
`ifdef CORR_PEAK_TIMEOUT_EN
    waiting = (state_q == ST_ALIGN) || (state_q == ST_WAIT_BUSY) ||
              (state_q == ST_WAIT_DONE);
    if (waiting) begin
      if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
        state_d = ST_IDLE;
        x_d     = x_q;
        y_d     = y_q;
        tmo_d   = 1'b1;
        valid_d = 1'b0;
        done_d  = 1'b1;
      end else if (state_d == state_q) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q    <= ST_IDLE;
      x_q        <= COORD_W'(X_MAX);
      y_q        <= COORD_W'(Y_MAX);
      run_best_q <= '0;
      run_x_q    <= '0;
      run_y_q    <= '0;
      first_q    <= 1'b0;
      best_q     <= '0;
      best_x_q   <= '0;
      best_y_q   <= '0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
`ifdef CORR_PEAK_TIMEOUT_EN
      cnt_q      <= '0;
      tmo_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      run_best_q <= run_best_d;
      run_x_q    <= run_x_d;
      run_y_q    <= run_y_d;
      first_q    <= first_d;
      best_q     <= best_d;
      best_x_q   <= best_x_d;
      best_y_q   <= best_y_d;
      valid_q    <= valid_d;
      done_q     <= done_d;
`ifdef CORR_PEAK_TIMEOUT_EN
      cnt_q      <= cnt_d;
      tmo_q      <= tmo_d;
`endif
    end
  end

`ifdef CORR_PEAK_TIMEOUT_EN
  assign oTimeout = tmo_q;
`else
  assign oTimeout = 1'b0;
`endif

  assign oXstart    = x_q;
  assign oYstart    = y_q;
  assign oBusy      = (state_q != ST_IDLE);
  assign oDone      = done_q;
  assign oValid     = valid_q;
  assign oBestScore = best_q;
  assign oBestX     = best_x_q;
  assign oBestY     = best_y_q;
  assign oState     = state_q;

endmodule

// File: tb/tb_corr_peak_search.sv
// Bench for corr_peak_search: two windows, a behavioural scorer and a raster-order reference.
module tb_corr_peak_search;
  import corr_peak_search_pkg::*;

  localparam int XMIN[2]  = '{0, 2};
  localparam int XMAX[2]  = '{3, 10};
  localparam int YMIN[2]  = '{0, 1};
  localparam int YMAX[2]  = '{3, 2};
  localparam int XSTEP[2] = '{1, 4};
  localparam int YSTEP[2] = '{1, 1};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic         start [2];
  logic         fin   [2];
  logic [31:0]  score [2];
  logic [12:0]  xs    [2];
  logic [12:0]  ys    [2];
  logic         busy  [2];
  logic         done  [2];
  logic         valid [2];
  logic [31:0]  best  [2];
  logic [12:0]  bx    [2];
  logic [12:0]  by    [2];
  logic         tmo   [2];
  state_t       st    [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    corr_peak_search #(
      .X_MIN(XMIN[g]), .X_MAX(XMAX[g]), .Y_MIN(YMIN[g]), .Y_MAX(YMAX[g]),
      .X_STEP(XSTEP[g]), .Y_STEP(YSTEP[g]), .TIMEOUT_CYCLES(64)
    ) u_dut (
      .iCLK(clk), .iRST_N(rst_n), .iStart(start[g]), .iFinished(fin[g]),
      .iScore(score[g]), .oXstart(xs[g]), .oYstart(ys[g]), .oBusy(busy[g]),
      .oDone(done[g]), .oValid(valid[g]), .oBestScore(best[g]), .oBestX(bx[g]),
      .oBestY(by[g]), .oTimeout(tmo[g]), .oState(st[g])
    );
  end

  // ---------------- scorer model ----------------
  int           mode [2];
  bit           hold [2];
  logic [31:0]  tab  [2][16][16];
  logic [12:0]  px   [2];
  logic [12:0]  py   [2];
  int           cnt  [2];
  bit           pend [2];
  logic [25:0]  seen0_q[$];
  logic [25:0]  seen1_q[$];

  function automatic logic [31:0] score_of(input int i, input int x, input int y);
    case (mode[i])
      0:       return 32'(1000 * (x + y));
      1:       return 32'd500;
      default: return tab[i][x][y];
    endcase
  endfunction

  // Restarts when the start coordinate changes; score register lags finished by one cycle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        fin[i]   <= 1'b1;
        px[i]    <= 13'(XMAX[i]);
        py[i]    <= 13'(YMAX[i]);
        cnt[i]   <= 0;
        pend[i]  <= 1'b0;
        score[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (fin[i] && (xs[i] != px[i] || ys[i] != py[i])) begin
          fin[i]   <= 1'b0;
          px[i]    <= xs[i];
          py[i]    <= ys[i];
          cnt[i]   <= $urandom_range(0, 4);
          score[i] <= 32'hFFFF_FFFF;
          if (i == 0) seen0_q.push_back({xs[i], ys[i]});
          else        seen1_q.push_back({xs[i], ys[i]});
        end else if (!fin[i] && !hold[i]) begin
          if (cnt[i] == 0) begin
            fin[i]  <= 1'b1;
            pend[i] <= 1'b1;
          end else begin
            cnt[i] <= cnt[i] - 1;
          end
        end
        if (pend[i]) begin
          score[i] <= score_of(i, int'(px[i]), int'(py[i]));
          pend[i]  <= 1'b0;
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [25:0] seen_at(input int i, input int k);
    if (i == 0) return seen0_q[k];
    return seen1_q[k];
  endfunction

  function automatic int seen_size(input int i);
    if (i == 0) return seen0_q.size();
    return seen1_q.size();
  endfunction

  task automatic check_reset_outputs(input int i, input string tag);
    check_val({tag, "_x"},     xs[i], XMAX[i]);
    check_val({tag, "_y"},     ys[i], YMAX[i]);
    check_val({tag, "_busy"},  busy[i], 0);
    check_val({tag, "_done"},  done[i], 0);
    check_val({tag, "_valid"}, valid[i], 0);
    check_val({tag, "_best"},  best[i], 0);
    check_val({tag, "_bx"},    bx[i], 0);
    check_val({tag, "_by"},    by[i], 0);
    check_val({tag, "_tmo"},   tmo[i], 0);
  endtask

  // Sweep with the raster reference; restart_at >= 0 pulses iStart again mid-sweep.
  task automatic run_sweep(input int i, input int m, input int restart_at, input string tag);
    logic [25:0] exp_q[$];
    logic [31:0] eb;
    int          ex, ey, n;
    bit          got;
    logic [31:0] s;
    mode[i] = m;
    if (i == 0) seen0_q.delete(); else seen1_q.delete();
    eb = 0; ex = 0; ey = 0;
    for (int y = YMIN[i]; y <= YMAX[i]; y += YSTEP[i]) begin
      for (int x = XMIN[i]; x <= XMAX[i]; x += XSTEP[i]) begin
        s = score_of(i, x, y);
        if (exp_q.size() == 0 || s > eb) begin
          eb = s; ex = x; ey = y;
        end
        exp_q.push_back({13'(x), 13'(y)});
      end
    end
    @(negedge clk); start[i] = 1'b1;
    @(negedge clk); start[i] = 1'b0;
    check_val({tag, "_busy"}, busy[i], 1);
    got = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (done[i]) begin
        got = 1'b1;
        break;
      end
      start[i] = (c == restart_at);
      @(negedge clk);
    end
    start[i] = 1'b0;
    check_val({tag, "_done_seen"}, got, 1);
    if (got) begin
      check_val({tag, "_best"},  best[i], eb);
      check_val({tag, "_bx"},    bx[i], ex);
      check_val({tag, "_by"},    by[i], ey);
      check_val({tag, "_valid"}, valid[i], 1);
      check_val({tag, "_busy0"}, busy[i], 0);
      check_val({tag, "_tmo"},   tmo[i], 0);
      check_val({tag, "_ncoord"}, seen_size(i), exp_q.size());
      n = (seen_size(i) < exp_q.size()) ? seen_size(i) : exp_q.size();
      for (int k = 0; k < n; k++) check_val({tag, "_coord"}, seen_at(i, k), exp_q[k]);
      check_val({tag, "_endxy"}, {xs[i], ys[i]}, exp_q[exp_q.size()-1]);
      @(negedge clk);
      check_val({tag, "_pulse"}, done[i], 0);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit hit;
    int n;
    for (int i = 0; i < 2; i++) begin
      start[i] = 1'b0; hold[i] = 1'b0; mode[i] = 0;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs(0, "rst0");
    check_reset_outputs(1, "rst1");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_sweep(0, 0, -1, "ramp");
    check_val("ramp_score", best[0], 6000);
    check_val("ramp_xy", {bx[0], by[0]}, {13'd3, 13'd3});
    run_sweep(0, 1, -1, "flat");
    check_val("flat_xy", {bx[0], by[0]}, 26'd0);
    run_sweep(1, 0, -1, "stride");
    check_val("stride_park_x", xs[1], 10);
    check_val("stride_park_y", ys[1], 2);

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 2; i++)
        for (int x = 0; x < 16; x++)
          for (int y = 0; y < 16; y++)
            tab[i][x][y] = (r % 2 == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      run_sweep(r % 2, 2, -1, "rand");
    end

    run_sweep(0, 2, 20, "restart");

    // Asynchronous reset while a position is being scored.
    mode[0] = 2;
    @(negedge clk); start[0] = 1'b1;
    @(negedge clk); start[0] = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 500; c++) begin
      if (st[0] == ST_WAIT_DONE && ys[0] == 13'd1) begin
        hit = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check_val("midrst_reach", hit, 1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs(0, "midrst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    run_sweep(0, 2, -1, "postrst");

`ifdef CORR_PEAK_TIMEOUT_EN
    hold[0] = 1'b1;
    @(negedge clk); start[0] = 1'b1;
    @(negedge clk); start[0] = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (st[0] == ST_WAIT_DONE) begin
        hit = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check_val("tmo_reach", hit, 1);
    n = 0;
    while (!done[0] && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_val("tmo_cycles", n, 64);
    check_val("tmo_flag", tmo[0], 1);
    check_val("tmo_valid", valid[0], 0);
    check_val("tmo_busy", busy[0], 0);
    check_val("tmo_xy", {xs[0], ys[0]}, {13'(XMIN[0]), 13'(YMIN[0])});
    @(negedge clk);
    check_val("tmo_pulse", done[0], 0);
    check_val("tmo_sticky", tmo[0], 1);
    hold[0] = 1'b0;
    repeat (10) @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk); start[0] = 1'b0;
    check_val("tmo_clear", tmo[0], 0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/corr_peak_search.md
# corr_peak_search

Sweep controller downstream of the correlation scorer. Steps the scorer's start coordinate over a rectangular window in raster order. Waits for each correlation to finish and keeps the highest score and its coordinate. Reports one result per sweep to the tracking/overlay logic.

## Interface
Parameters:
- X_MIN, 0, first window X
- X_MAX, 31, last window X (inclusive)
- Y_MIN, 0, first window Y
- Y_MAX, 31, last window Y (inclusive)
- X_STEP, 1, X increment
- Y_STEP, 1, Y increment
- TIMEOUT_CYCLES, 1048576, watchdog limit (used only with the macro)

Ports:
- iCLK  in  1  system clock, single clock domain
- iRST_N  in  1  asynchronous active-low reset
- iStart  in  1  one-cycle sweep request
- iFinished  in  1  scorer done flag
- iScore  in  32  scorer result, unsigned
- oXstart  out  13  scorer start X
- oYstart  out  13  scorer start Y
- oBusy  out  1  sweep in progress
- oDone  out  1  one-cycle pulse when a sweep ends
- oValid  out  1  best result holds a completed sweep
- oBestScore  out  32  highest score of the last sweep
- oBestX  out  13  X of that score
- oBestY  out  13  Y of that score
- oTimeout  out  1  sticky abort flag

## Operation
- States:
  - IDLE
  - ALIGN: wait for the scorer to be idle
  - WAIT_BUSY: wait for the scorer to acknowledge restart
  - WAIT_DONE: wait for the scorer to finish
  - SETTLE: capture the score
- Coordinates park at (X_MAX,Y_MAX) in IDLE. The window must contain at least 2 positions, which makes the park point differ from (0,0) and from (X_MIN,Y_MIN). Violating this is an elaboration error.
- IDLE: iStart → ALIGN, oBusy=1, clear oTimeout, clear running best (score 0).
- iStart is ignored while oBusy=1.
- ALIGN: on iFinished=1, drive (X_MIN,Y_MIN) → WAIT_BUSY.
- Rule: oXstart/oYstart change only while iFinished=1.
- WAIT_BUSY: iFinished=0 → WAIT_DONE.
- WAIT_DONE: iFinished=1 → SETTLE.
- SETTLE: sample iScore. The scorer registers its output one cycle after raising finished.
  - If iScore > running best, or this is the first position: update best score and coordinate.
  - Ties keep the earlier position in raster order.
  - Not last position: advance the coordinate (it is safe, since iFinished=1) → WAIT_BUSY.
  - Last position: copy running best to outputs, oValid=1, oDone pulse, oBusy=0 → IDLE.
- Advance order:
  - X += X_STEP while the next X ≤ X_MAX.
  - Otherwise X=X_MIN and Y += Y_STEP.
  - Last position: next X > X_MAX and next Y > Y_MAX. Coordinates then remain at the final position, which is the park position only when the strides hit X_MAX/Y_MAX exactly.
- Arithmetic: step computation uses 14 bits to avoid wrap. Comparison is unsigned 32-bit.
- Reset, any time, mid-sweep included: state IDLE, oXstart=X_MAX, oYstart=Y_MAX, all other outputs 0. The partial sweep is discarded.
- oBest* outputs hold until the next sweep completes. oValid=1 from the first completion until a timeout abort or reset.

## Timing
- Coordinate update → iFinished falls one cycle later, given scorer behaviour.
- iFinished rise at edge t → SETTLE at edge t+1 → iScore sampled at edge t+2.
- Per position: scorer run + 3 controller cycles.
- Last SETTLE edge: oDone=1 for exactly one cycle, with oValid, oBest* and oBusy=0 updated on the same edge.

## Configuration
- CORR_PEAK_TIMEOUT_EN defined:
  - A counter runs in ALIGN, WAIT_BUSY and WAIT_DONE, and clears on every state change.
  - Reaching TIMEOUT_CYCLES aborts the sweep: oTimeout=1 (sticky until next iStart), oValid=0, oDone pulse, coordinates unchanged → IDLE.
- Undefined: no counter; waits indefinitely; oTimeout tied 0.

## Structure
- Shared package/header holds:
  - coordinate width 13, score width 32
  - SEARCH_H_RES/SEARCH_V_RES
  - state encoding constants
- One natural sub-module, corr_raster_step: combinational next-coordinate and last-position flag from current X/Y and window parameters.

## Test plan
- Scorer model returning 1000·(X+Y), window 0..3×0..3 step 1, iStart → oDone after 16 captures, oBestScore=6000, oBestX=3, oBestY=3, oValid=1.
- Constant score 500 everywhere → best (X_MIN,Y_MIN)=(0,0) per tie rule.
- Window X 2..10 step 4 (2,6,10), Y 1..2 → scorer sees exactly 6 start coordinates in raster order, then coordinates park at (10,2).
- iStart pulsed again mid-sweep → ignored; sweep result identical to the undisturbed run.
- iRST_N low during WAIT_DONE → outputs immediately oXstart=X_MAX, oYstart=Y_MAX, others 0; fresh iStart completes normally.
- With CORR_PEAK_TIMEOUT_EN, TIMEOUT_CYCLES=64, iFinished held 0 → oDone pulse and oTimeout=1 after 64 cycles in WAIT_DONE, oValid=0. Next iStart clears oTimeout.
